// File: rtl/lsu_pkg.sv
// Shared load-path definitions: funct3 encodings, access sizes and the
// sequencing states used by load_align_unit.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ1  = 3'd1,
    ST_WAIT1 = 3'd2,
    ST_REQ2  = 3'd3,
    ST_WAIT2 = 3'd4,
    ST_RESP  = 3'd5
  } state_e;

  function automatic logic [3:0] size_of(input logic [2:0] funct3);
    case (funct3)
      F3_LB, F3_LBU: size_of = 4'd1;
      F3_LH, F3_LHU: size_of = 4'd2;
      F3_LW, F3_LWU: size_of = 4'd4;
      F3_LD:         size_of = 4'd8;
      default:       size_of = 4'd0;
    endcase
  endfunction

  // LD and LWU only exist on a 64-bit datapath.
  function automatic logic is_legal(input logic [2:0] funct3, input logic rv64);
    case (funct3)
      F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: is_legal = 1'b1;
      F3_LD, F3_LWU:                       is_legal = rv64;
      default:                             is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Byte-lane extraction and sign/zero extension of a (possibly two-beat) load.
module load_extend
  import lsu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = $clog2(XLEN / 8)
) (
  input  logic [2*XLEN-1:0] beats,
  input  logic [OFF_W-1:0]  off,
  input  logic [2:0]        funct3,
  output logic [XLEN-1:0]   rsp_data
);

  logic [XLEN-1:0] raw_s;

  // Shift the addressed byte down to lane 0, then extend the kept bytes.
  always_comb begin
    raw_s = XLEN'(beats >> {off, 3'b000});
    case (funct3)
      F3_LB:   rsp_data = XLEN'($signed(raw_s[7:0]));
      F3_LBU:  rsp_data = XLEN'(raw_s[7:0]);
      F3_LH:   rsp_data = XLEN'($signed(raw_s[15:0]));
      F3_LHU:  rsp_data = XLEN'(raw_s[15:0]);
      F3_LW:   rsp_data = XLEN'($signed(raw_s[31:0]));
      F3_LWU:  rsp_data = XLEN'(raw_s[31:0]);
      F3_LD:   rsp_data = raw_s;
      default: rsp_data = '0;
    endcase
  end

endmodule

// File: rtl/load_align_unit.sv
// Load-data unit: aligns memory reads, splits word-crossing loads into two
// beats (or rejects them), extends the result and hands it to writeback.
module load_align_unit
  import lsu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int ADDR_W         = 32,
  parameter bit SPLIT_MISALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_funct3,
  input  logic [4:0]        req_rd,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_data,
  output logic [4:0]        rsp_rd,
  output logic              rsp_err
);

  localparam int BYTES = XLEN / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam logic RV64 = (XLEN == 64);
  localparam logic [ADDR_W-1:0] BEAT_STRIDE = ADDR_W'(BYTES);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [4:0]        rd_q, rd_d;
  logic              cross_q, cross_d;
  logic [XLEN-1:0]   beat0_q, beat0_d;
  logic              req_ready_q, req_ready_d;
  logic              mem_req_valid_q, mem_req_valid_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]   rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  logic [OFF_W-1:0]  req_off_s;
  logic [4:0]        req_end_s;
  logic              req_cross_s;
  logic              req_legal_s;
  logic [ADDR_W-1:0] base_addr_s;
  logic [2*XLEN-1:0] ext_beats_s;
  logic [XLEN-1:0]   ext_data_s;

  // Classify the incoming request before it is latched.
  always_comb begin
    req_off_s   = req_addr[OFF_W-1:0];
    req_end_s   = 5'(req_off_s) + 5'(size_of(req_funct3));
    req_cross_s = (req_end_s > 5'(BYTES));
    req_legal_s = is_legal(req_funct3, RV64);
  end

  // In WAIT2 the first beat is already held; otherwise the live beat is beat0.
  always_comb begin
    if (state_q == ST_WAIT2) begin
      ext_beats_s = {mem_rdata, beat0_q};
    end else begin
      ext_beats_s = {{XLEN{1'b0}}, mem_rdata};
    end
  end

  load_extend #(
    .XLEN  (XLEN),
    .OFF_W (OFF_W)
  ) u_extend (
    .beats    (ext_beats_s),
    .off      (addr_q[OFF_W-1:0]),
    .funct3   (funct3_q),
    .rsp_data (ext_data_s)
  );

  // Next-state logic; outputs are derived from the next state so they leave a flop.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    funct3_d   = funct3_q;
    rd_d       = rd_q;
    cross_d    = cross_q;
    beat0_d    = beat0_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d     = req_addr;
          funct3_d   = req_funct3;
          rd_d       = req_rd;
          cross_d    = req_cross_s;
          beat0_d    = '0;
          rsp_data_d = '0;
          if (!req_legal_s || (req_cross_s && !SPLIT_MISALIGN)) begin
            rsp_err_d = 1'b1;
            state_d   = ST_RESP;
          end else begin
            rsp_err_d = 1'b0;
            state_d   = ST_REQ1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ1: begin
        if (mem_req_ready) state_d = ST_WAIT1;
        else               state_d = ST_REQ1;
      end
      ST_WAIT1: begin
        if (mem_rvalid) begin
          beat0_d = mem_rdata;
          if (cross_q) begin
            state_d = ST_REQ2;
          end else begin
            state_d    = ST_RESP;
            rsp_data_d = ext_data_s;
          end
        end else begin
          state_d = ST_WAIT1;
        end
      end
      ST_REQ2: begin
        if (mem_req_ready) state_d = ST_WAIT2;
        else               state_d = ST_REQ2;
      end
      ST_WAIT2: begin
        if (mem_rvalid) begin
          state_d    = ST_RESP;
          rsp_data_d = ext_data_s;
        end else begin
          state_d = ST_WAIT2;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d   = ST_IDLE;
          rsp_err_d = 1'b0;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    base_addr_s     = {addr_d[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    req_ready_d     = (state_d == ST_IDLE);
    mem_req_valid_d = (state_d == ST_REQ1) || (state_d == ST_REQ2);
    rsp_valid_d     = (state_d == ST_RESP);
    case (state_d)
      ST_REQ1: mem_addr_d = base_addr_s;
      ST_REQ2: mem_addr_d = base_addr_s + BEAT_STRIDE;
      default: mem_addr_d = '0;
    endcase
  end

  // State, latched request and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      funct3_q        <= 3'b000;
      rd_q            <= 5'd0;
      cross_q         <= 1'b0;
      beat0_q         <= '0;
      req_ready_q     <= 1'b1;
      mem_req_valid_q <= 1'b0;
      mem_addr_q      <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_data_q      <= '0;
      rsp_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      funct3_q        <= funct3_d;
      rd_q            <= rd_d;
      cross_q         <= cross_d;
      beat0_q         <= beat0_d;
      req_ready_q     <= req_ready_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_addr_q      <= mem_addr_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_data_q      <= rsp_data_d;
      rsp_err_q       <= rsp_err_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_addr      = mem_addr_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_rd        = rd_q;
  assign rsp_err       = rsp_err_q;

endmodule
